atm_bank_responder: RTL and testbench



---
 rtl/atm_bank_responder_if.sv | 29 ++
 rtl/atm_bank_responder.sv | 254 +++++++++++++++++++++++++
 tb/tb_atm_bank_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/atm_bank_responder_if.sv
// Request/response channel between the ATM controller (master) and the bank responder (slave).
// A beat transfers on any rising edge where valid and ready are both high; valid holds its payload until then.
interface atm_bank_responder_if #(
    parameter int DATA_W = 12,
    parameter int AMT_W  = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [DATA_W-1:0] req_acct;
    logic [DATA_W-1:0] req_pin;
    logic [DATA_W-1:0] req_dst;
    logic [AMT_W-1:0]  req_amount;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0]        rsp_status;
    logic [DATA_W-1:0] rsp_balance;
    logic [DATA_W-1:0] rsp_dst_balance;

    modport slave (
        input  req_valid, req_op, req_acct, req_pin, req_dst, req_amount, rsp_ready,
        output req_ready, rsp_valid, rsp_status, rsp_balance, rsp_dst_balance
    );

    modport master (
        output req_valid, req_op, req_acct, req_pin, req_dst, req_amount, rsp_ready,
        input  req_ready, rsp_valid, rsp_status, rsp_balance, rsp_dst_balance
    );
endinterface

// File: rtl/atm_bank_responder.sv
// Bank-side account server: looks up, authenticates and atomically commits ATM transactions.
// Optional feature: define PIN_LOCKOUT_EN for per-account wrong-PIN lockout.
module atm_bank_responder #(
    parameter int NUM_ACCOUNTS = 3,
    parameter int DATA_W       = 12,
    parameter int AMT_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    atm_bank_responder_if.slave  bus,
    output logic [2:0]           o_dbg_state
);
    localparam int IDX_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;

    localparam logic [2:0] OP_DEP  = 3'd0;
    localparam logic [2:0] OP_WD   = 3'd1;
    localparam logic [2:0] OP_XFR  = 3'd3;

    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_NO_ACCT  = 3'd1;
    localparam logic [2:0] ST_BAD_PIN  = 3'd2;
    localparam logic [2:0] ST_INSUFF   = 3'd3;
    localparam logic [2:0] ST_NO_DST   = 3'd4;
    localparam logic [2:0] ST_BAD_OP   = 3'd5;
    localparam logic [2:0] ST_OVERFLOW = 3'd6;
    localparam logic [2:0] ST_LOCKED   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_CHECK  = 3'd2,
        S_COMMIT = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    function automatic logic [DATA_W-1:0] rst_num(input int i);
        case (i)
            0:       rst_num = DATA_W'(12'h123);
            1:       rst_num = DATA_W'(12'h456);
            2:       rst_num = DATA_W'(12'h789);
            default: rst_num = DATA_W'(i);
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] rst_bal(input int i);
        case (i)
            0:       rst_bal = DATA_W'(12'h457);
            1:       rst_bal = DATA_W'(12'h8AE);
            2:       rst_bal = DATA_W'(12'hD05);
            default: rst_bal = '0;
        endcase
    endfunction

    // Account numbers and PINs never change, so only balances live in flops.
    state_t            r_state;
    state_t            w_next;
    logic              w_req_ready;
    logic              w_rsp_valid;
    logic              w_accept;

    logic [DATA_W-1:0] r_bal [NUM_ACCOUNTS];
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_acct;
    logic [DATA_W-1:0] r_pin;
    logic [DATA_W-1:0] r_dst;
    logic [AMT_W-1:0]  r_amt;
    logic [IDX_W-1:0]  r_src_idx;
    logic [IDX_W-1:0]  r_dst_idx;
    logic              r_src_hit;
    logic              r_dst_hit;
    logic [2:0]        r_status;
    logic [2:0]        r_rsp_status;
    logic [DATA_W-1:0] r_rsp_bal;
    logic [DATA_W-1:0] r_rsp_dst;

    logic [IDX_W-1:0]  w_src_idx;
    logic [IDX_W-1:0]  w_dst_idx;
    logic              w_src_hit;
    logic              w_dst_hit;
    logic [DATA_W-1:0] w_src_bal;
    logic [DATA_W-1:0] w_dst_bal;
    logic [DATA_W-1:0] w_src_pin;
    logic [DATA_W-1:0] w_amt;
    logic [DATA_W:0]   w_src_sum;
    logic [DATA_W:0]   w_dst_sum;
    logic [DATA_W-1:0] w_new_src;
    logic              w_locked;
    logic [2:0]        w_status;
    logic              w_is_xfr;

`ifdef PIN_LOCKOUT_EN
    logic [1:0]        r_fail [NUM_ACCOUNTS];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) w_next = S_LOOKUP;
            end
            S_LOOKUP: w_next = S_CHECK;
            S_CHECK:  w_next = S_COMMIT;
            S_COMMIT: w_next = S_RESP;
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && bus.req_valid;
    assign w_is_xfr = (r_op == OP_XFR);

    // Search from the top down so the lowest matching index is the one left standing.
    always_comb begin
        w_src_hit = 1'b0;
        w_dst_hit = 1'b0;
        w_src_idx = '0;
        w_dst_idx = '0;
        for (int i = NUM_ACCOUNTS - 1; i >= 0; i--) begin
            if (rst_num(i) == r_acct) begin
                w_src_hit = 1'b1;
                w_src_idx = IDX_W'(i);
            end
            if (rst_num(i) == r_dst) begin
                w_dst_hit = 1'b1;
                w_dst_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_src_bal = '0;
        w_dst_bal = '0;
        w_src_pin = '0;
        w_locked  = 1'b0;
        for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            if (r_src_idx == IDX_W'(i)) begin
                w_src_bal = r_bal[i];
                w_src_pin = rst_num(i);
`ifdef PIN_LOCKOUT_EN
                w_locked  = (r_fail[i] == 2'd3);
`endif
            end
            if (r_dst_idx == IDX_W'(i)) w_dst_bal = r_bal[i];
        end
    end

    assign w_amt     = DATA_W'(r_amt);
    assign w_src_sum = {1'b0, w_src_bal} + {1'b0, w_amt};
    assign w_dst_sum = {1'b0, w_dst_bal} + {1'b0, w_amt};
    assign w_new_src = (r_op == OP_DEP) ? w_src_sum[DATA_W-1:0]
                     : ((r_op == OP_WD) || w_is_xfr) ? (w_src_bal - w_amt)
                     : w_src_bal;

    always_comb begin
        w_status = ST_OK;
        if ((r_op > 3'd4) || (w_is_xfr && (r_dst == r_acct)))
            w_status = ST_BAD_OP;
        else if (!r_src_hit)
            w_status = ST_NO_ACCT;
        else if (w_locked)
            w_status = ST_LOCKED;
        else if (w_src_pin != r_pin)
            w_status = ST_BAD_PIN;
        else if (w_is_xfr && !r_dst_hit)
            w_status = ST_NO_DST;
        else if (((r_op == OP_WD) || w_is_xfr) && (w_amt > w_src_bal))
            w_status = ST_INSUFF;
        else if ((r_op == OP_DEP) && w_src_sum[DATA_W])
            w_status = ST_OVERFLOW;
        else if (w_is_xfr && w_dst_sum[DATA_W])
            w_status = ST_OVERFLOW;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) r_bal[i] <= rst_bal(i);
`ifdef PIN_LOCKOUT_EN
            for (int i = 0; i < NUM_ACCOUNTS; i++) r_fail[i] <= 2'd0;
`endif
            r_op         <= '0;
            r_acct       <= '0;
            r_pin        <= '0;
            r_dst        <= '0;
            r_amt        <= '0;
            r_src_idx    <= '0;
            r_dst_idx    <= '0;
            r_src_hit    <= 1'b0;
            r_dst_hit    <= 1'b0;
            r_status     <= ST_OK;
            r_rsp_status <= ST_OK;
            r_rsp_bal    <= '0;
            r_rsp_dst    <= '0;
        end else begin
            if (w_accept) begin
                r_op   <= bus.req_op;
                r_acct <= bus.req_acct;
                r_pin  <= bus.req_pin;
                r_dst  <= bus.req_dst;
                r_amt  <= bus.req_amount;
            end
            if (r_state == S_LOOKUP) begin
                r_src_idx <= w_src_idx;
                r_dst_idx <= w_dst_idx;
                r_src_hit <= w_src_hit;
                r_dst_hit <= w_dst_hit;
            end
            if (r_state == S_CHECK) r_status <= w_status;
            // Source and destination are written on this one edge, so a transfer is never half-applied.
            if (r_state == S_COMMIT) begin
                for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                    if ((r_status == ST_OK) && (r_src_idx == IDX_W'(i)))
                        r_bal[i] <= w_new_src;
                    if ((r_status == ST_OK) && w_is_xfr && (r_dst_idx == IDX_W'(i)))
                        r_bal[i] <= w_dst_sum[DATA_W-1:0];
`ifdef PIN_LOCKOUT_EN
                    if (r_src_idx == IDX_W'(i)) begin
                        if ((r_status == ST_BAD_PIN) && (r_fail[i] != 2'd3))
                            r_fail[i] <= r_fail[i] + 2'd1;
                        else if ((r_status == ST_OK) || (r_status == ST_NO_DST) ||
                                 (r_status == ST_INSUFF) || (r_status == ST_OVERFLOW))
                            r_fail[i] <= 2'd0;
                    end
`endif
                end
                r_rsp_status <= r_status;
                if ((r_status == ST_NO_ACCT) || (r_status == ST_BAD_OP))
                    r_rsp_bal <= '0;
                else if (r_status == ST_OK)
                    r_rsp_bal <= w_new_src;
                else
                    r_rsp_bal <= w_src_bal;
                r_rsp_dst <= ((r_status == ST_OK) && w_is_xfr) ? w_dst_sum[DATA_W-1:0] : '0;
            end
        end
    end

    assign bus.req_ready       = w_req_ready & rst;
    assign bus.rsp_valid       = w_rsp_valid;
    assign bus.rsp_status      = r_rsp_status;
    assign bus.rsp_balance     = r_rsp_bal;
    assign bus.rsp_dst_balance = r_rsp_dst;
    assign o_dbg_state         = r_state;
endmodule

// File: tb/tb_atm_bank_responder.sv
// Self-checking bench for atm_bank_responder: vector tables plus backpressure and mid-commit reset sequences.
module tb_atm_bank_responder;
    localparam logic [2:0] DEP = 3'd0, WD = 3'd1, BAL = 3'd2, XFR = 3'd3, AUTH = 3'd4;
`ifdef PIN_LOCKOUT_EN
    localparam logic [2:0] LOCK_ST = 3'd7;
`else
    localparam logic [2:0] LOCK_ST = 3'd0;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [11:0] acct;
        logic [11:0] pin;
        logic [11:0] dst;
        logic [7:0]  amt;
        logic [2:0]  st;
        logic [11:0] bal;
        logic [11:0] dbal;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;
    int         n_checks;
    int         n_fail;
    logic [26:0] exp_q[$];
    vec_t       va[$];
    vec_t       vb[$];

    atm_bank_responder_if #(.DATA_W(12), .AMT_W(8)) bus ();

    atm_bank_responder #(.NUM_ACCOUNTS(3), .DATA_W(12), .AMT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [11:0] acct, input logic [11:0] pin,
                                input logic [11:0] dst, input logic [7:0] amt, input logic [2:0] st,
                                input logic [11:0] bal, input logic [11:0] dbal);
        vec_t v;
        v.op = op; v.acct = acct; v.pin = pin; v.dst = dst; v.amt = amt;
        v.st = st; v.bal = bal; v.dbal = dbal;
        return v;
    endfunction

    task automatic drive_req(input vec_t v);
        bus.req_valid  = 1'b1;
        bus.req_op     = v.op;
        bus.req_acct   = v.acct;
        bus.req_pin    = v.pin;
        bus.req_dst    = v.dst;
        bus.req_amount = v.amt;
    endtask

    task automatic scramble_req();
        bus.req_op     = 3'($urandom_range(0, 7));
        bus.req_acct   = 12'($urandom_range(0, 4095));
        bus.req_pin    = 12'($urandom_range(0, 4095));
        bus.req_dst    = 12'($urandom_range(0, 4095));
        bus.req_amount = 8'($urandom_range(0, 255));
    endtask

    task automatic compare_rsp(input string tag);
        logic [26:0] e;
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, " status"},   32'(bus.rsp_status),      32'(e[26:24]));
        check({tag, " balance"},  32'(bus.rsp_balance),     32'(e[23:12]));
        check({tag, " dst_bal"},  32'(bus.rsp_dst_balance), 32'(e[11:0]));
    endtask

    // Counts edges after acceptance until rsp_valid; returns the count (capped at the budget).
    task automatic wait_rsp(output int n);
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int n;
        exp_q.push_back({v.st, v.bal, v.dbal});
        @(posedge clk); #1;
        drive_req(v);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        scramble_req();
        check({tag, " req_ready_busy"}, 32'(bus.req_ready), 32'd0);
        wait_rsp(n);
        check({tag, " latency"}, 32'(n), 32'd3);
        if (bus.rsp_valid) compare_rsp(tag);
        else void'(exp_q.pop_front());
        @(posedge clk); #1;
        check({tag, " back_to_idle"}, {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);
    endtask

    initial begin
        vec_t v;
        int   n;
        n_checks = 0;
        n_fail   = 0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req_op = '0; bus.req_acct = '0; bus.req_pin = '0; bus.req_dst = '0; bus.req_amount = '0;

        va.push_back(mk(DEP,  12'h123, 12'h123, 12'h000, 8'h10, 3'd0, 12'h467, 12'h000));
        va.push_back(mk(WD,   12'h123, 12'h123, 12'h000, 8'hFF, 3'd0, 12'h368, 12'h000));
        va.push_back(mk(WD,   12'h123, 12'h123, 12'h000, 8'hFF, 3'd0, 12'h269, 12'h000));
        va.push_back(mk(WD,   12'h123, 12'h123, 12'h000, 8'hFF, 3'd0, 12'h16A, 12'h000));
        va.push_back(mk(WD,   12'h123, 12'h123, 12'h000, 8'hFF, 3'd0, 12'h06B, 12'h000));
        va.push_back(mk(WD,   12'h123, 12'h123, 12'h000, 8'h1B, 3'd0, 12'h050, 12'h000));
        va.push_back(mk(WD,   12'h123, 12'h123, 12'h000, 8'hFF, 3'd3, 12'h050, 12'h000));
        va.push_back(mk(WD,   12'h123, 12'h123, 12'h000, 8'h50, 3'd0, 12'h000, 12'h000));
        va.push_back(mk(BAL,  12'h789, 12'h789, 12'h000, 8'h00, 3'd0, 12'hD05, 12'h000));
        va.push_back(mk(3'd7, 12'h123, 12'h123, 12'h000, 8'h00, 3'd5, 12'h000, 12'h000));
        va.push_back(mk(3'd6, 12'h999, 12'h000, 12'h000, 8'h00, 3'd5, 12'h000, 12'h000));
        va.push_back(mk(BAL,  12'h999, 12'h999, 12'h000, 8'h00, 3'd1, 12'h000, 12'h000));
        va.push_back(mk(AUTH, 12'h123, 12'h000, 12'h000, 8'h00, 3'd2, 12'h000, 12'h000));
        va.push_back(mk(XFR,  12'h123, 12'h123, 12'hAAA, 8'h01, 3'd4, 12'h000, 12'h000));
        va.push_back(mk(XFR,  12'h123, 12'h123, 12'h456, 8'h01, 3'd3, 12'h000, 12'h000));
        va.push_back(mk(DEP,  12'h456, 12'h456, 12'h000, 8'h00, 3'd0, 12'h8AE, 12'h000));
        va.push_back(mk(DEP,  12'h789, 12'h789, 12'h000, 8'hFF, 3'd0, 12'hE04, 12'h000));
        va.push_back(mk(DEP,  12'h789, 12'h789, 12'h000, 8'hFB, 3'd0, 12'hEFF, 12'h000));
        va.push_back(mk(DEP,  12'h789, 12'h789, 12'h000, 8'hFF, 3'd0, 12'hFFE, 12'h000));
        va.push_back(mk(DEP,  12'h789, 12'h789, 12'h000, 8'h01, 3'd0, 12'hFFF, 12'h000));
        va.push_back(mk(DEP,  12'h789, 12'h789, 12'h000, 8'h01, 3'd6, 12'hFFF, 12'h000));

        vb.push_back(mk(BAL,  12'h123, 12'h123, 12'h000, 8'h00, 3'd0, 12'h457, 12'h000));
        vb.push_back(mk(BAL,  12'h456, 12'h456, 12'h000, 8'h00, 3'd0, 12'h8AE, 12'h000));
        vb.push_back(mk(BAL,  12'h789, 12'h789, 12'h000, 8'h00, 3'd0, 12'hD05, 12'h000));
        vb.push_back(mk(XFR,  12'h456, 12'h456, 12'h123, 8'h20, 3'd0, 12'h88E, 12'h477));
        vb.push_back(mk(XFR,  12'h789, 12'h789, 12'h789, 8'h05, 3'd5, 12'h000, 12'h000));
        vb.push_back(mk(XFR,  12'h456, 12'h456, 12'h789, 8'hFF, 3'd0, 12'h78F, 12'hE04));
        vb.push_back(mk(XFR,  12'h456, 12'h456, 12'h789, 8'hFF, 3'd0, 12'h690, 12'hF03));
        vb.push_back(mk(XFR,  12'h456, 12'h456, 12'h789, 8'hFF, 3'd6, 12'h690, 12'h000));
        vb.push_back(mk(BAL,  12'h789, 12'h789, 12'h000, 8'h00, 3'd0, 12'hF03, 12'h000));
        vb.push_back(mk(AUTH, 12'h456, 12'h456, 12'h000, 8'h00, 3'd0, 12'h690, 12'h000));
        vb.push_back(mk(AUTH, 12'h456, 12'h000, 12'h000, 8'h00, 3'd2, 12'h690, 12'h000));
        vb.push_back(mk(AUTH, 12'h456, 12'h000, 12'h000, 8'h00, 3'd2, 12'h690, 12'h000));
        vb.push_back(mk(AUTH, 12'h456, 12'h000, 12'h000, 8'h00, 3'd2, 12'h690, 12'h000));
        vb.push_back(mk(AUTH, 12'h456, 12'h456, 12'h000, 8'h00, LOCK_ST, 12'h690, 12'h000));

        // Reset and reset values.
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset req_ready_low", 32'(bus.req_ready), 32'd0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b1;
        #1;
        check("reset req_ready_high", 32'(bus.req_ready), 32'd1);
        check("reset rsp_fields", {5'd0, bus.rsp_status, bus.rsp_balance, bus.rsp_dst_balance}, 32'd0);

        for (int i = 0; i < va.size(); i++) run_txn(va[i], $sformatf("vecA%0d", i));

        // Response backpressure with a competing request that must be ignored.
        v = mk(BAL, 12'h789, 12'h789, 12'h000, 8'h00, 3'd0, 12'hFFF, 12'h000);
        exp_q.push_back({v.st, v.bal, v.dbal});
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        drive_req(v);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_rsp(n);
        check("bp latency", 32'(n), 32'd3);
        drive_req(mk(DEP, 12'h123, 12'h123, 12'h000, 8'h55, 3'd0, 12'h000, 12'h000));
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp hold%0d", c),
                  {2'd0, bus.rsp_valid, bus.req_ready, bus.rsp_status, bus.rsp_balance, bus.rsp_dst_balance},
                  {2'd0, 1'b1, 1'b0, exp_q[0]});
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        compare_rsp("bp");
        @(posedge clk); #1;
        check("bp back_to_idle", {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);
        run_txn(mk(BAL, 12'h123, 12'h123, 12'h000, 8'h00, 3'd0, 12'h000, 12'h000), "bp ignored_req");

        // Reset while a transfer sits in COMMIT.
        @(posedge clk); #1;
        drive_req(mk(XFR, 12'h456, 12'h456, 12'h123, 8'h20, 3'd0, 12'h000, 12'h000));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_commit state", 32'(dbg_state), 32'd3);
        rst = 1'b0;
        #2;
        check("rst_commit outputs", {30'd0, bus.rsp_valid, bus.req_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_commit idle", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < vb.size(); i++) run_txn(vb[i], $sformatf("vecB%0d", i));

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
